// File: rtl/pipelined_math_pkg.sv
// Shared helpers for the chunk-skewed pipelined-math stages.
package pipelined_math_pkg;

    function automatic int unsigned ceil_division(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned slice_count(input int unsigned width, input int unsigned chunk);
        return ceil_division(width, chunk);
    endfunction

endpackage

// File: rtl/shift_register.sv
// Enable-gated delay line of DEPTH stages (DEPTH >= 1), async active-low reset.
module shift_register #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/deskew.sv
// Realigns chunk-skewed slices into whole words behind a valid/ready output.
// Optional macro DESKEW_ZERO_FILL_EN: out reads 0 whenever out_valid is low.
module deskew
    import pipelined_math_pkg::*;
#(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned CHUNK = 1,
    localparam int unsigned N     = slice_count(WIDTH, CHUNK),
    localparam int unsigned OCC_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic             in_mask,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             stall,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned LAST_LO = (N - 1) * CHUNK;

    logic             w_adv;
    logic             w_xfer;
    logic             w_inc;
    logic             w_valid_dly;
    logic [WIDTH-1:0] w_aligned;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [OCC_W-1:0] r_occ;

    assign w_adv  = en & (~r_out_valid | out_ready);
    assign w_xfer = r_out_valid & out_ready;
    assign w_inc  = w_adv & in_mask;

    // Slice k waits N-1-k advances; the last (possibly narrower) slice feeds the output register directly.
    for (genvar k = 0; k < N; k++) begin : g_slice
        if (k == N - 1) begin : g_bypass
            assign w_aligned[WIDTH-1:LAST_LO] = in[WIDTH-1:LAST_LO];
        end else begin : g_delay
            shift_register #(
                .DEPTH(N - 1 - k),
                .WIDTH(CHUNK)
            ) u_dly (
                .i_clk  (clk),
                .i_rst_n(rst),
                .i_en   (w_adv),
                .i_d    (in[k*CHUNK +: CHUNK]),
                .o_q    (w_aligned[k*CHUNK +: CHUNK])
            );
        end
    end

    if (N > 1) begin : g_valid_chain
        shift_register #(
            .DEPTH(N - 1),
            .WIDTH(1)
        ) u_vdly (
            .i_clk  (clk),
            .i_rst_n(rst),
            .i_en   (w_adv),
            .i_d    (in_mask),
            .o_q    (w_valid_dly)
        );
    end else begin : g_valid_bypass
        assign w_valid_dly = in_mask;
    end

    // A transfer with the pipeline frozen must still retire the word so it is not presented twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_valid_dly;
`ifdef DESKEW_ZERO_FILL_EN
            r_out       <= w_valid_dly ? w_aligned : '0;
`else
            r_out       <= w_aligned;
`endif
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
`ifdef DESKEW_ZERO_FILL_EN
            r_out       <= '0;
`endif
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_inc && !w_xfer)      w_occ_nxt = r_occ + OCC_W'(1);
        else if (!w_inc && w_xfer) w_occ_nxt = r_occ - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_occ <= '0;
        else      r_occ <= w_occ_nxt;
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign stall     = ~w_adv;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_deskew.sv
// Self-checking bench for deskew: instance A (8/2, N=4) and B (7/3, N=3) against a slot-indexed model.
module tb_deskew;

    logic       clk = 1'b0;
    logic       rst;
    logic       en  [2];
    logic       rdy [2];
    logic       msk [2];
    logic [7:0] din_a;
    logic [6:0] din_b;
    logic [7:0] out_a;
    logic [6:0] out_b;
    logic       ov_a, ov_b, st_a, st_b;
    logic [2:0] oc_a;
    logic [1:0] oc_b;

    always #5 clk = ~clk;

    deskew #(.WIDTH(8), .CHUNK(2)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .in(din_a), .in_mask(msk[0]),
        .out(out_a), .out_valid(ov_a), .out_ready(rdy[0]), .stall(st_a), .occupancy(oc_a)
    );

    deskew #(.WIDTH(7), .CHUNK(3)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .in(din_b), .in_mask(msk[1]),
        .out(out_b), .out_valid(ov_b), .out_ready(rdy[1]), .stall(st_b), .occupancy(oc_b)
    );

    // Model: slot s is the word whose slice 0 is on the bus at advance count s.
    logic [7:0] W [2][512];
    logic       M [2][512];
    int         A [2];
    logic       ev[2];
    int         total = 0;
    int         bad   = 0;
    int         max_occ;

    function automatic int n_of(int i);     return (i == 0) ? 4 : 3; endfunction
    function automatic int chunk_of(int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int width_of(int i); return (i == 0) ? 8 : 7; endfunction

    function automatic logic [7:0] word_at(int i, int s);
        if (s < 0) return 8'h00;
        return W[i][s];
    endfunction

    function automatic logic mask_at(int i, int s);
        if (s < 0) return 1'b0;
        return M[i][s];
    endfunction

    function automatic logic [7:0] bus(int i);
        logic [7:0] b;
        logic [7:0] w;
        b = '0;
        for (int bi = 0; bi < width_of(i); bi++) begin
            w = word_at(i, A[i] - bi / chunk_of(i));
            b[bi] = w[bi];
        end
        return b;
    endfunction

    function automatic logic [7:0] exp_out(int i);
        logic [7:0] w;
        w = word_at(i, A[i] - n_of(i));
`ifdef DESKEW_ZERO_FILL_EN
        if (!ev[i]) w = 8'h00;
`endif
        return w;
    endfunction

    function automatic int exp_occ(int i);
        int c;
        c = ev[i] ? 1 : 0;
        for (int j = 1; j < n_of(i); j++) c += mask_at(i, A[i] - j) ? 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] dut_out(int i);   return (i == 0) ? {24'h0, out_a} : {25'h0, out_b}; endfunction
    function automatic logic        dut_valid(int i); return (i == 0) ? ov_a : ov_b; endfunction
    function automatic logic        dut_stall(int i); return (i == 0) ? st_a : st_b; endfunction
    function automatic logic [31:0] dut_occ(int i);   return (i == 0) ? {29'h0, oc_a} : {30'h0, oc_b}; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            A[i]  = 0;
            ev[i] = 1'b0;
            for (int s = 0; s < 512; s++) begin
                W[i][s] = 8'h00;
                M[i][s] = 1'b0;
            end
        end
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic cycle();
        logic       adv [2];
        logic       xf  [2];
        logic [7:0] tmp;
        string      p;
        din_a  = bus(0);
        tmp    = bus(1);
        din_b  = tmp[6:0];
        msk[0] = mask_at(0, A[0]);
        msk[1] = mask_at(1, A[1]);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? "A" : "B";
            adv[i] = en[i] & (~ev[i] | rdy[i]);
            xf[i]  = ev[i] & rdy[i];
            check({p, "_out"},   dut_out(i),   {24'h0, exp_out(i)});
            check({p, "_valid"}, {31'h0, dut_valid(i)}, {31'h0, ev[i]});
            check({p, "_occ"},   dut_occ(i),   32'(exp_occ(i)));
            check({p, "_stall"}, {31'h0, dut_stall(i)}, {31'h0, ~adv[i]});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (adv[i]) begin
                A[i]++;
                ev[i] = mask_at(i, A[i] - n_of(i));
            end else if (xf[i]) begin
                ev[i] = 1'b0;
            end
        end
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge follows.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_A_valid", {31'h0, ov_a}, 32'h0);
        check("rst_B_valid", {31'h0, ov_b}, 32'h0);
        check("rst_A_occ", {29'h0, oc_a}, 32'h0);
        check("rst_B_occ", {30'h0, oc_b}, 32'h0);
        check("rst_A_out", {24'h0, out_a}, 32'h0);
        en[0] = 1'b0;
        en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; rdy[i] = 1'b1; msk[i] = 1'b0;
        end
        din_a = '0;
        din_b = '0;
        reset_model();
        #3;
        check("init_out", {24'h0, out_a}, 32'h0);
        check("init_valid", {31'h0, ov_a}, 32'h0);
        check("init_occ", {29'h0, oc_a}, 32'h0);
        check("init_stall", {31'h0, st_a}, 32'h0);
        en[0] = 1'b0; en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Alignment, invalid slot, back-to-back words.
        W[0][0] = 8'hA5; M[0][0] = 1'b1;
        W[0][1] = 8'hFF; M[0][1] = 1'b0;
        W[0][8] = 8'h11; M[0][8] = 1'b1;
        W[0][9] = 8'h22; M[0][9] = 1'b1;
        W[0][10] = 8'h33; M[0][10] = 1'b1;
        W[1][0] = 8'h5A; M[1][0] = 1'b1;
        W[1][1] = 8'h7F; M[1][1] = 1'b0;
        max_occ = 0;
        for (int i = 0; i < 2; i++) begin en[i] = 1'b1; rdy[i] = 1'b1; end
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (int'(oc_a) > max_occ) max_occ = int'(oc_a);
            if (c == 2) check("ragged_out", {25'h0, out_b}, 32'h5A);
            if (c == 3) check("align_out", {24'h0, out_a}, 32'hA5);
            if (c == 3) check("align_valid", {31'h0, ov_a}, 32'h1);
            if (c == 4) check("align_once", {31'h0, ov_a}, 32'h0);
`ifdef DESKEW_ZERO_FILL_EN
            if (c == 4) check("zf_A", {24'h0, out_a}, 32'h00);
            if (c == 3) check("zf_B", {25'h0, out_b}, 32'h00);
`else
            if (c == 4) check("stale_A", {24'h0, out_a}, 32'hFF);
            if (c == 3) check("stale_B", {25'h0, out_b}, 32'h7F);
`endif
            if (c == 11) check("b2b_0", {24'h0, out_a}, 32'h11);
            if (c == 12) check("b2b_1", {24'h0, out_a}, 32'h22);
            if (c == 13) check("b2b_2", {24'h0, out_a}, 32'h33);
        end
        check("occ_peak", 32'(max_occ), 32'd3);

        // Backpressure on A.
        do_reset();
        W[0][0] = 8'hA5; M[0][0] = 1'b1;
        W[0][1] = 8'h3C; M[0][1] = 1'b1;
        for (int i = 0; i < 2; i++) begin en[i] = 1'b1; rdy[i] = 1'b1; end
        for (int c = 0; c < 14; c++) begin
            rdy[0] = !(c >= 4 && c <= 6);
            cycle();
            if (c >= 4 && c <= 6) begin
                check("bp_hold_out", {24'h0, out_a}, 32'hA5);
                check("bp_hold_valid", {31'h0, ov_a}, 32'h1);
            end
            if (c == 7) check("bp_next", {24'h0, out_a}, 32'h3C);
        end

        // Async reset with words in flight (B already presenting one).
        do_reset();
        for (int i = 0; i < 2; i++) begin
            W[i][0] = 8'h12; M[i][0] = 1'b1;
            W[i][1] = 8'h34; M[i][1] = 1'b1;
            en[i] = 1'b1; rdy[i] = 1'b0;
        end
        for (int c = 0; c < 3; c++) cycle();
        check("pre_rst_A_occ", {29'h0, oc_a}, 32'd2);
        check("pre_rst_B_valid", {31'h0, ov_b}, 32'h1);
        do_reset();
        for (int i = 0; i < 2; i++) begin en[i] = 1'b1; rdy[i] = 1'b1; end
        for (int c = 0; c < 8; c++) cycle();

        // Random traffic, including en low while a transfer completes.
        do_reset();
        for (int s = 0; s < 400; s++) begin
            W[0][s] = 8'($urandom);
            W[1][s] = 8'($urandom) & 8'h7F;
            M[0][s] = 1'($urandom_range(0, 1));
            M[1][s] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                en[i]  = ($urandom_range(0, 9) != 0);
                rdy[i] = ($urandom_range(0, 9) < 7);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
